// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte producers, the UART transmitter and the arbiter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface uart_tx_arbiter_if;
    logic [7:0] m_tx_byte;
    logic       m_transmit;
    logic       m_full;
    logic [7:0] c_tx_byte;
    logic       c_transmit;
    logic       c_full;
    logic       mon_priority;
    logic [7:0] u_tx_byte;
    logic       u_transmit;
    logic       u_is_transmitting;
    logic       owner;
    logic       busy;
    logic [1:0] ovf;
    logic       timeout_err;
    logic       clr_err;

    modport slave (
        input  m_tx_byte, m_transmit, c_tx_byte, c_transmit, mon_priority,
               u_is_transmitting, clr_err,
        output m_full, c_full, u_tx_byte, u_transmit, owner, busy, ovf, timeout_err
    );

    modport master (
        output m_tx_byte, m_transmit, c_tx_byte, c_transmit, mon_priority,
               u_is_transmitting, clr_err,
        input  m_full, c_full, u_tx_byte, u_transmit, owner, busy, ovf, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the monitor (index 0) and the CPU (index 1),
// each feeding its own FIFO; a small FSM drains them one byte at a time.
module uart_tx_arbiter #(
    parameter int DEPTH_LOG2    = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(START_TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [TW-1:0]         TMR_ONE  = TW'(1);
    localparam logic [TW-1:0]         TMR_LOAD = TW'(START_TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

    state_t                         state_q, state_d;
    logic [1:0][DEPTH_LOG2-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0][DEPTH_LOG2:0]       cnt_q, cnt_d;
    logic [7:0]                     mem_q [2][DEPTH];
    logic [7:0]                     tx_byte_q, tx_byte_d;
    logic                           u_transmit_q, u_transmit_d;
    logic                           owner_q, owner_d;
    logic                           last_q, last_d;
    logic [TW-1:0]                  tmr_q, tmr_d;
    logic [1:0]                     ovf_q, ovf_d;
    logic                           terr_q, terr_d;
    logic [1:0]                     full_q, full_d;
    logic                           busy_q, busy_d;

    logic [1:0]                     push_s, pop_s, nempty_s, accept_s, ovf_set_s;
    logic [1:0][7:0]                push_byte_s;
    logic                           sel_s, terr_set_s;

    assign push_s         = {bus.c_transmit, bus.m_transmit};
    assign push_byte_s[0] = bus.m_tx_byte;
    assign push_byte_s[1] = bus.c_tx_byte;
    assign nempty_s       = {|cnt_q[1], |cnt_q[0]};

    // Scheduler: requester selection, launch pulse and start-timeout handling
    always_comb begin
        state_d    = state_q;
        pop_s      = 2'b00;
        sel_s      = 1'b0;
        tx_byte_d  = tx_byte_q;
        owner_d    = owner_q;
        last_d     = last_q;
        tmr_d      = tmr_q;
        terr_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.u_is_transmitting && (nempty_s != 2'b00)) begin
                    if (bus.mon_priority) begin
                        sel_s = ~nempty_s[0];
                    end else if (nempty_s == 2'b11) begin
                        sel_s = ~last_q;
                    end else begin
                        sel_s = ~nempty_s[0];
                    end
                    pop_s[sel_s] = 1'b1;
                    tx_byte_d    = mem_q[sel_s][rd_ptr_q[sel_s]];
                    owner_d      = sel_s;
                    state_d      = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                tmr_d   = TMR_LOAD;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (bus.u_is_transmitting) begin
                    state_d = WAIT_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                    // Abandon the byte when the count would hit zero this cycle
                    if (tmr_q <= TMR_ONE) begin
                        terr_set_s = 1'b1;
                        last_d     = owner_q;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT_START;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.u_is_transmitting) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and sticky error flags; a full FIFO still accepts when it pops
    always_comb begin
        accept_s  = 2'b00;
        ovf_set_s = 2'b00;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        for (int r = 0; r < 2; r++) begin
            accept_s[r]  = push_s[r] && ((cnt_q[r] != FULL_CNT) || pop_s[r]);
            ovf_set_s[r] = push_s[r] && (cnt_q[r] == FULL_CNT) && !pop_s[r];
            if (accept_s[r]) begin
                wr_ptr_d[r] = wr_ptr_q[r] + PTR_ONE;
            end else begin
                wr_ptr_d[r] = wr_ptr_q[r];
            end
            if (pop_s[r]) begin
                rd_ptr_d[r] = rd_ptr_q[r] + PTR_ONE;
            end else begin
                rd_ptr_d[r] = rd_ptr_q[r];
            end
            case ({accept_s[r], pop_s[r]})
                2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
                2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
        ovf_d        = (bus.clr_err ? 2'b00 : ovf_q) | ovf_set_s;
        terr_d       = (bus.clr_err ? 1'b0 : terr_q) | terr_set_s;
        full_d       = {cnt_d[1] == FULL_CNT, cnt_d[0] == FULL_CNT};
        busy_d       = (state_d != IDLE) || (|cnt_d[0]) || (|cnt_d[1]);
        u_transmit_d = (state_d == LAUNCH);
    end

    // Control and status registers; outputs are taken straight from these flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            tx_byte_q    <= 8'h00;
            u_transmit_q <= 1'b0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            tmr_q        <= '0;
            ovf_q        <= 2'b00;
            terr_q       <= 1'b0;
            full_q       <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            tx_byte_q    <= tx_byte_d;
            u_transmit_q <= u_transmit_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            tmr_q        <= tmr_d;
            ovf_q        <= ovf_d;
            terr_q       <= terr_d;
            full_q       <= full_d;
            busy_q       <= busy_d;
        end
    end

    // FIFO storage needs no reset; the flushed pointers make old contents unreachable
    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (accept_s[r]) begin
                mem_q[r][wr_ptr_q[r]] <= push_byte_s[r];
            end
        end
    end

    assign bus.u_tx_byte   = tx_byte_q;
    assign bus.u_transmit  = u_transmit_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.ovf         = ovf_q;
    assign bus.timeout_err = terr_q;
    assign bus.m_full      = full_q[0];
    assign bus.c_full      = full_q[1];
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a behavioural UART records every launched byte
// and stays busy for a programmable number of cycles, or can be held busy or dead.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int         ucnt = 0;
    int         busy_len = 3;
    bit         uart_hold = 1'b0;
    bit         uart_dead = 1'b0;
    logic [7:0] sent [$];

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.DEPTH_LOG2(2), .START_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: samples the launch pulse mid-cycle and records the byte
    always @(negedge clk) begin
        if (rst) begin
            ucnt <= 0;
        end else if (bus.u_transmit) begin
            sent.push_back(bus.u_tx_byte);
            if (!uart_dead) ucnt <= busy_len;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
        end
    end
    assign bus.u_is_transmitting = uart_hold || (ucnt != 0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sent.delete();
    endtask

    task automatic push_m(input logic [7:0] b);
        bus.m_transmit = 1'b1;
        bus.m_tx_byte  = b;
        step();
        bus.m_transmit = 1'b0;
    endtask

    task automatic push_c(input logic [7:0] b);
        bus.c_transmit = 1'b1;
        bus.c_tx_byte  = b;
        step();
        bus.c_transmit = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            step();
            n++;
        end
        check_eq("idle_reached", bus.busy, 1'b0);
    endtask

    task automatic wait_pulse(input int limit, output int t);
        int n = 0;
        while (!bus.u_transmit && n < limit) begin
            step();
            n++;
        end
        check_eq("pulse_seen", bus.u_transmit, 1'b1);
        t = cyc;
    endtask

    task automatic check_order(input string tag, input logic [7:0] exp [$]);
        check_eq({tag, "_count"}, sent.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < sent.size()) check_eq($sformatf("%s_%0d", tag, i), sent[i], exp[i]);
            else check_eq($sformatf("%s_%0d_missing", tag, i), 32'hFFFF_FFFF, exp[i]);
        end
    endtask

    initial begin
        int t0;
        int t1;
        int n;
        int n0;
        logic [7:0] exp_q [$];

        rst = 1'b1;
        bus.m_tx_byte = 8'h00; bus.m_transmit = 1'b0;
        bus.c_tx_byte = 8'h00; bus.c_transmit = 1'b0;
        bus.mon_priority = 1'b0; bus.clr_err = 1'b0;
        step();
        step();
        check_eq("rst_u_transmit", bus.u_transmit, 1'b0);
        check_eq("rst_u_tx_byte", bus.u_tx_byte, 8'h00);
        check_eq("rst_owner", bus.owner, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_full", {bus.c_full, bus.m_full}, 2'b00);
        check_eq("rst_ovf", bus.ovf, 2'b00);
        check_eq("rst_timeout", bus.timeout_err, 1'b0);
        rst = 1'b0;
        sent.delete();

        // Single byte: pulse two cycles after the strobe
        busy_len = 10;
        push_m(8'h41);
        check_eq("single_no_pulse_yet", bus.u_transmit, 1'b0);
        check_eq("single_busy", bus.busy, 1'b1);
        step();
        check_eq("single_pulse", bus.u_transmit, 1'b1);
        check_eq("single_byte", bus.u_tx_byte, 8'h41);
        check_eq("single_owner", bus.owner, 1'b0);
        step();
        check_eq("single_pulse_end", bus.u_transmit, 1'b0);
        check_eq("single_byte_hold", bus.u_tx_byte, 8'h41);
        wait_idle(50);
        exp_q = '{8'h41};
        check_order("single", exp_q);

        // Round-robin
        do_reset();
        busy_len = 3;
        bus.mon_priority = 1'b0;
        bus.m_transmit = 1'b1; bus.m_tx_byte = 8'h10;
        bus.c_transmit = 1'b1; bus.c_tx_byte = 8'h20;
        step();
        bus.m_tx_byte = 8'h11; bus.c_tx_byte = 8'h21;
        step();
        bus.m_transmit = 1'b0; bus.c_transmit = 1'b0;
        wait_idle(200);
        exp_q = '{8'h10, 8'h20, 8'h11, 8'h21};
        check_order("rr", exp_q);

        // Strict monitor priority
        do_reset();
        bus.mon_priority = 1'b1;
        bus.m_transmit = 1'b1; bus.m_tx_byte = 8'h10;
        bus.c_transmit = 1'b1; bus.c_tx_byte = 8'h20;
        step();
        bus.m_tx_byte = 8'h11; bus.c_tx_byte = 8'h21;
        step();
        bus.m_transmit = 1'b0; bus.c_transmit = 1'b0;
        wait_idle(200);
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h21};
        check_order("prio", exp_q);

        // Overflow with the UART held busy, then push coinciding with a pop while full
        do_reset();
        bus.mon_priority = 1'b0;
        uart_hold = 1'b1;
        push_c(8'h00);
        push_c(8'h01);
        push_c(8'h02);
        check_eq("ovf_not_full_at3", bus.c_full, 1'b0);
        push_c(8'h03);
        check_eq("ovf_full_at4", bus.c_full, 1'b1);
        check_eq("ovf_none_yet", bus.ovf, 2'b00);
        push_c(8'h04);
        check_eq("ovf_drop_full", bus.c_full, 1'b1);
        check_eq("ovf_flag_cpu", bus.ovf, 2'b10);
        uart_hold = 1'b0;
        push_c(8'h05);
        check_eq("ovf_push_pop_full", bus.c_full, 1'b1);
        check_eq("ovf_push_pop_no_new", bus.ovf, 2'b10);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check_eq("ovf_cleared", bus.ovf, 2'b00);
        wait_idle(200);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05};
        check_order("ovf", exp_q);

        // Start timeout: UART never answers
        do_reset();
        uart_dead = 1'b1;
        push_m(8'h55);
        push_m(8'h66);
        wait_pulse(10, t0);
        check_eq("to_first_byte", bus.u_tx_byte, 8'h55);
        n = 0;
        while (!bus.timeout_err && n < 40) begin
            step();
            n++;
        end
        check_eq("to_latency", cyc - t0, 32'd17);
        wait_pulse(10, t1);
        check_eq("to_next_launch", t1 - t0, 32'd18);
        check_eq("to_next_byte", bus.u_tx_byte, 8'h66);
        wait_idle(100);
        check_eq("to_sticky", bus.timeout_err, 1'b1);
        uart_dead = 1'b0;

        // Async reset during WAIT_DONE with monitor bytes queued and CPU FIFO overflowed
        busy_len = 10;
        bus.mon_priority = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.m_transmit = (i < 4);
            bus.m_tx_byte  = 8'hA0 + 8'(i);
            bus.c_transmit = 1'b1;
            bus.c_tx_byte  = 8'hB0 + 8'(i);
            step();
        end
        bus.m_transmit = 1'b0; bus.c_transmit = 1'b0;
        check_eq("ar_pre_uart_busy", bus.u_is_transmitting, 1'b1);
        check_eq("ar_pre_owner", bus.owner, 1'b0);
        check_eq("ar_pre_cfull", bus.c_full, 1'b1);
        check_eq("ar_pre_ovf", bus.ovf, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_u_transmit", bus.u_transmit, 1'b0);
        check_eq("ar_busy", bus.busy, 1'b0);
        check_eq("ar_full", {bus.c_full, bus.m_full}, 2'b00);
        check_eq("ar_ovf", bus.ovf, 2'b00);
        check_eq("ar_timeout", bus.timeout_err, 1'b0);
        step();
        rst = 1'b0;
        n0 = sent.size();
        repeat (30) step();
        check_eq("ar_no_pulses", sent.size(), n0);
        check_eq("ar_still_idle", bus.busy, 1'b0);
        push_m(8'hC3);
        wait_idle(100);
        check_eq("ar_new_count", sent.size(), n0 + 1);
        if (sent.size() > 0) check_eq("ar_new_byte", sent[sent.size() - 1], 8'hC3);
        else check_eq("ar_new_byte_missing", 32'hFFFF_FFFF, 8'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
